// File: rtl/fp_collector_pkg.sv
// Shared types and helpers for the FPmul result collector.
package fp_collector_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    DONE_ST = 2'd2
  } state_e;

  localparam int CNT_W = 16;

  // Pointer width: index bits plus one wrap bit for full/empty detection.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fp_result_fifo.sv
// Sync FIFO with a registered head word. The head register is refreshed
// from storage one edge after a write, so there is no write-to-output bypass.
// Occupancy counts the word shown on dout until it is popped.
module fp_result_fifo
  import fp_collector_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             dout_ready,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             pop,
  output logic             full,
  output logic             empty,
  output logic             push_drop
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             do_push;

  assign empty      = (wr_q == rd_q);
  assign full       = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
  assign pop        = dout_valid_q & dout_ready;
  // A pop frees the slot in the same edge, so a full FIFO still accepts.
  assign do_push    = push & (~full | pop);
  assign push_drop  = push & full & ~pop;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

  // Next pointers and next head word; head looks past a word popped this edge.
  always_comb begin
    wr_d         = wr_q + PW'(do_push);
    rd_d         = rd_q + PW'(pop);
    dout_valid_d = (wr_q != rd_d);
    dout_d       = dout_valid_d ? mem_q[rd_d[AW-1:0]] : dout_q;
  end

  // Storage array, no reset needed: contents are qualified by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  end

  // Pointers and registered head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q         <= '0;
      rd_q         <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

endmodule

// File: rtl/fp_result_collector.sv
// Regenerates the FPmul result strobe from D_READY, buffers FP_Z in a FIFO
// towards a ready/valid consumer, and reports when the end-of-run drain is done.
module fp_result_collector
  import fp_collector_pkg::*;
#(
  parameter int LATENCY = 5,
  parameter int DEPTH   = 8,
  parameter int WIDTH   = 32
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             D_READY,
  input  logic             END_SIM,
  input  logic [WIDTH-1:0] FP_Z,
  output logic [WIDTH-1:0] DOUT,
  output logic             DOUT_VALID,
  input  logic             DOUT_READY,
  output logic [CNT_W-1:0] RESULT_CNT,
  output logic             OVF,
  output logic             DONE
);

  logic [LATENCY-1:0] vld_pipe_q, vld_pipe_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               done_q;
  state_e             state_q;
  logic               tap, pop, push_drop, fifo_full, fifo_empty, drained;

  // Tap is high in the cycle FP_Z belongs to an operand seen LATENCY edges ago.
  assign tap = vld_pipe_q[LATENCY-1];

  fp_result_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (CLK),
    .rst_n      (RST_n),
    .push       (tap),
    .din        (FP_Z),
    .dout_ready (DOUT_READY),
    .dout       (DOUT),
    .dout_valid (DOUT_VALID),
    .pop        (pop),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .push_drop  (push_drop)
  );

  // Nothing in flight, nothing stored, nothing shown, and no operand arriving
  // this very cycle (it would otherwise be lost from the drain accounting).
  assign drained = ~|vld_pipe_q & ~D_READY & fifo_empty & ~fifo_full & ~DOUT_VALID;

  // Valid shift register, pop counter and sticky overflow next-state.
  always_comb begin
    vld_pipe_d    = '0;
    vld_pipe_d[0] = D_READY;
    for (int i = 1; i < LATENCY; i++) vld_pipe_d[i] = vld_pipe_q[i-1];
    cnt_d = cnt_q + CNT_W'(pop);
    ovf_d = ovf_q | push_drop;
  end

  // Datapath state registers.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      vld_pipe_q <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  // Run/drain/done sequencer; DONE is terminal until reset.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= RUN;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (END_SIM) state_q <= DRAIN;
        end
        DRAIN: begin
          if (drained) begin
            state_q <= DONE_ST;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= DONE_ST;
          done_q  <= 1'b1;
        end
      endcase
    end
  end

  assign RESULT_CNT = cnt_q;
  assign OVF        = ovf_q;
  assign DONE       = done_q;

endmodule

// File: tb/tb_fp_result_collector.sv
// Directed bench for fp_result_collector (LATENCY=5, DEPTH=8, WIDTH=32).
// A small delay line stands in for FPmul so FP_Z lines up with the operand.
module tb_fp_result_collector;

  localparam int LAT = 5;
  localparam int DEP = 8;
  localparam int W   = 32;
  localparam logic [W-1:0] JUNK = 32'hDEAD_BEEF;

  logic          CLK = 1'b0;
  logic          RST_n = 1'b0;
  logic          D_READY = 1'b0;
  logic          END_SIM = 1'b0;
  logic          DOUT_READY = 1'b0;
  logic [W-1:0]  FP_Z;
  logic [W-1:0]  DOUT;
  logic          DOUT_VALID;
  logic [15:0]   RESULT_CNT;
  logic          OVF;
  logic          DONE;

  logic [W-1:0]  src = JUNK;
  logic [W-1:0]  zp [LAT];
  logic [31:0]   expq [$];
  int            checks = 0;
  int            errors = 0;
  int            npop, cyc, first_pop, last_pop;

  fp_result_collector #(.LATENCY(LAT), .DEPTH(DEP), .WIDTH(W)) dut (
    .CLK        (CLK),
    .RST_n      (RST_n),
    .D_READY    (D_READY),
    .END_SIM    (END_SIM),
    .FP_Z       (FP_Z),
    .DOUT       (DOUT),
    .DOUT_VALID (DOUT_VALID),
    .DOUT_READY (DOUT_READY),
    .RESULT_CNT (RESULT_CNT),
    .OVF        (OVF),
    .DONE       (DONE)
  );

  always #5 CLK = ~CLK;

  // Multiplier stand-in: operand value appears on FP_Z LAT edges later.
  always @(posedge CLK) begin
    zp[0] <= src;
    for (int i = 1; i < LAT; i++) zp[i] <= zp[i-1];
  end
  assign FP_Z = zp[LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Score a pop about to happen at the next edge, then advance one cycle.
  task automatic step();
    logic [31:0] e;
    if (DOUT_VALID && DOUT_READY) begin
      checks++;
      assert (expq.size() > 0) else begin
        errors++;
        $error("FAIL pop_extra: observed pop of 0x%08h expected no pop", DOUT);
      end
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("pop_data", DOUT, e);
      end
      npop++;
      last_pop = cyc;
      if (first_pop < 0) first_pop = cyc;
    end
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic op(input logic [W-1:0] v);
    D_READY = 1'b1;
    src     = v;
    step();
    D_READY = 1'b0;
    src     = JUNK;
  endtask

  task automatic do_reset();
    RST_n = 1'b0; D_READY = 1'b0; END_SIM = 1'b0; DOUT_READY = 1'b0; src = JUNK;
    expq.delete();
    @(posedge CLK); #1;
    RST_n = 1'b1;
    npop = 0; first_pop = -1; last_pop = -1;
  endtask

  initial begin
    cyc = 0;
    // ---- reset state
    do_reset();
    chk("rst_dout",  DOUT, 32'h0);
    chk("rst_valid", 32'(DOUT_VALID), 32'd0);
    chk("rst_cnt",   32'(RESULT_CNT), 32'd0);
    chk("rst_ovf",   32'(OVF), 32'd0);
    chk("rst_done",  32'(DONE), 32'd0);

    // ---- single op: sampled at edge A, pushed at A+5, visible after A+6
    op(32'h4080_0000);
    repeat (4) step();
    chk("single_valid_a4", 32'(DOUT_VALID), 32'd0);
    step();
    chk("single_valid_a5", 32'(DOUT_VALID), 32'd0);
    step();
    chk("single_valid_a6", 32'(DOUT_VALID), 32'd1);
    chk("single_dout", DOUT, 32'h4080_0000);
    DOUT_READY = 1'b1;
    expq.push_back(32'h4080_0000);
    step();
    chk("single_cnt", 32'(RESULT_CNT), 32'd1);
    chk("single_valid_after_pop", 32'(DOUT_VALID), 32'd0);
    chk("single_npop", 32'(npop), 32'd1);

    // ---- burst of 20 with ready held high
    do_reset();
    DOUT_READY = 1'b1;
    for (int i = 0; i < 20; i++) begin
      expq.push_back(32'h3F80_0000 + 32'(i));
      op(32'h3F80_0000 + 32'(i));
    end
    repeat (12) step();
    chk("burst_npop", 32'(npop), 32'd20);
    chk("burst_no_gap", 32'(last_pop - first_pop), 32'd19);
    chk("burst_ovf", 32'(OVF), 32'd0);
    chk("burst_cnt", 32'(RESULT_CNT), 32'd20);
    chk("burst_left", 32'(expq.size()), 32'd0);

    // ---- backpressure: 10 ops into 8 slots, 9th tap drops
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (i < DEP) expq.push_back(32'h0000_1000 + 32'(i));
      op(32'h0000_1000 + 32'(i));
    end
    repeat (3) step();
    chk("bp_ovf_at_8th", 32'(OVF), 32'd0);
    step();
    chk("bp_ovf_at_9th", 32'(OVF), 32'd1);
    chk("bp_valid", 32'(DOUT_VALID), 32'd1);
    chk("bp_dout_hold", DOUT, 32'h0000_1000);
    repeat (2) step();
    chk("bp_dout_hold2", DOUT, 32'h0000_1000);
    DOUT_READY = 1'b1;
    repeat (12) step();
    chk("bp_npop", 32'(npop), 32'd8);
    chk("bp_cnt", 32'(RESULT_CNT), 32'd8);
    chk("bp_ovf_sticky", 32'(OVF), 32'd1);
    chk("bp_left", 32'(expq.size()), 32'd0);

    // ---- full FIFO with push and pop on the same edges
    do_reset();
    for (int i = 0; i < 12; i++) begin
      expq.push_back(32'h0000_2000 + 32'(i));
      op(32'h0000_2000 + 32'(i));
    end
    step();
    DOUT_READY = 1'b1;
    repeat (4) step();
    DOUT_READY = 1'b0;
    repeat (2) step();
    chk("full_pp_ovf", 32'(OVF), 32'd0);
    chk("full_pp_cnt", 32'(RESULT_CNT), 32'd4);
    chk("full_pp_head", DOUT, 32'h0000_2004);
    npop = 0;
    DOUT_READY = 1'b1;
    repeat (12) step();
    chk("full_pp_remaining", 32'(npop), 32'd8);
    chk("full_pp_cnt_total", 32'(RESULT_CNT), 32'd12);
    chk("full_pp_ovf_end", 32'(OVF), 32'd0);

    // ---- drain: END_SIM with the last D_READY at edge E, DONE after E+8
    do_reset();
    DOUT_READY = 1'b1;
    END_SIM = 1'b1;
    expq.push_back(32'h0000_5000);
    op(32'h0000_5000);
    repeat (5) step();
    chk("drain_done_e5", 32'(DONE), 32'd0);
    repeat (2) step();
    chk("drain_done_e7", 32'(DONE), 32'd0);
    chk("drain_cnt", 32'(RESULT_CNT), 32'd1);
    step();
    chk("drain_done_e8", 32'(DONE), 32'd1);
    END_SIM = 1'b0;
    step();
    chk("done_sticky_endsim", 32'(DONE), 32'd1);
    expq.push_back(32'h0000_6000);
    op(32'h0000_6000);
    repeat (8) step();
    chk("done_late_push_cnt", 32'(RESULT_CNT), 32'd2);
    chk("done_late_push_done", 32'(DONE), 32'd1);

    // ---- async reset mid-burst with OVF set and DONE high
    DOUT_READY = 1'b0;
    for (int i = 0; i < 12; i++) op(32'h0000_7000 + 32'(i));
    repeat (3) step();
    chk("pre_rst_ovf", 32'(OVF), 32'd1);
    #3;
    RST_n = 1'b0;
    #1;
    chk("arst_valid", 32'(DOUT_VALID), 32'd0);
    chk("arst_cnt", 32'(RESULT_CNT), 32'd0);
    chk("arst_done", 32'(DONE), 32'd0);
    chk("arst_ovf", 32'(OVF), 32'd0);
    chk("arst_dout", DOUT, 32'h0);
    @(posedge CLK); #1;
    RST_n = 1'b1;
    expq.delete();
    npop = 0;
    DOUT_READY = 1'b1;
    expq.push_back(32'h0000_8000);
    op(32'h0000_8000);
    repeat (8) step();
    chk("post_rst_cnt", 32'(RESULT_CNT), 32'd1);
    chk("post_rst_ovf", 32'(OVF), 32'd0);
    chk("post_rst_done", 32'(DONE), 32'd0);
    chk("post_rst_left", 32'(expq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_result_collector.md
Name: fp_result_collector

Overview:
Consumer-side counterpart to the operand stream driven by data_maker into FPmul. It regenerates the result-valid strobe by delaying the operand D_READY by the multiplier latency, and captures FP_Z on that strobe into a small FIFO. The FIFO drains to a downstream ready/valid consumer, for example a file writer or a checker. It also tracks an end-of-simulation drain and raises DONE once every in-flight result has been delivered. This replaces the ad-hoc delayer + data_sink pairing with one reusable, synthesizable block.

Parameters:
LATENCY, 5, FPmul pipeline depth in cycles (D_READY-to-FP_Z alignment); legal range 1..16
DEPTH, 8, FIFO entries; power of two, at least 2
WIDTH, 32, result word width

Ports:
CLK  in  1  system clock, rising edge
RST_n  in  1  asynchronous active-low reset
D_READY  in  1  operand valid, from the same source that drives FPmul inputs
END_SIM  in  1  source finished; level, sampled each cycle
FP_Z  in  WIDTH  FPmul result
DOUT  out  WIDTH  FIFO head word
DOUT_VALID  out  1  DOUT holds a valid result
DOUT_READY  in  1  downstream accepts DOUT this cycle
RESULT_CNT  out  16  results accepted downstream (pops)
OVF  out  1  sticky: a result was dropped because the FIFO was full
DONE  out  1  drain complete

Behaviour:
- Reset (async, RST_n=0): valid shift register cleared, FIFO empty, pointers 0.
- Reset values: DOUT=0, DOUT_VALID=0, RESULT_CNT=0, OVF=0, DONE=0, state=RUN.
- Valid alignment: LATENCY-stage shift register vld[0..LATENCY-1]; vld[0]<=D_READY each edge.
  - Tap vld[LATENCY-1] is high in the cycle when the FP_Z of an operand sampled LATENCY edges earlier is present.
  - D_READY sampled at edge k means FP_Z is written at edge k+LATENCY.
- Push: tap=1 and (not full, or pop in the same cycle) writes FP_Z at the write pointer.
  - Tap=1, full and no pop: word dropped, OVF<=1 (sticky until reset), pointers unchanged.
- Pop: DOUT_VALID and DOUT_READY both high at an edge.
  - Read pointer advances.
  - RESULT_CNT increments and wraps 0xFFFF->0 silently.
- DOUT/DOUT_VALID are registered from the FIFO head; no combinational bypass.
  - A push into an empty FIFO gives DOUT_VALID=1 one cycle later (edge k+LATENCY+1).
- DOUT holds stable while DOUT_VALID=1 and DOUT_READY=0.
- Pointers are log2(DEPTH)+1 bits with wrap-bit full/empty detection.
  - Simultaneous push+pop leaves occupancy unchanged, including when full or when occupancy is 1.
- State machine:
  - RUN: normal operation; on END_SIM=1 go to DRAIN.
  - DRAIN: push/pop continue; D_READY is still sampled.
    - Go to DONE when the shift register is all zero, the FIFO is empty and DOUT_VALID=0.
    - This needs at least LATENCY cycles after the last D_READY.
  - DONE: DONE=1, terminal until reset.
    - Any later tap=1 still pushes; DONE stays 1.
    - DONE stays 1 if END_SIM deasserts.
- END_SIM and D_READY high in the same cycle: that operand is still tracked and delivered before DONE.
- Reset mid-operation clears everything immediately; in-flight results are discarded without setting OVF.

Decomposition:
- Package fp_collector_pkg holds:
  - state encoding typedef (RUN, DRAIN, DONE_ST);
  - CNT_W=16;
  - a function computing pointer width from DEPTH.
- One sub-module, fp_result_fifo: sync FIFO with WIDTH/DEPTH params, registered head output, full/empty flags and push_drop output.
- The top level keeps the valid shift register, FSM and counter.

Test Plan:
- Single op: D_READY=1 for 1 cycle at edge 10, FP_Z=0x40800000 at edge 15 -> DOUT_VALID=1 after edge 16, DOUT=0x40800000; with DOUT_READY=1, RESULT_CNT=1.
- Burst: D_READY=1 for 20 cycles, DOUT_READY tied 1, FP_Z=incrementing 0x3F800000+i -> 20 words in order, no gaps after the first, OVF=0, RESULT_CNT=20.
- Backpressure: DOUT_READY=0, burst of 10 with DEPTH=8 -> 8 stored, OVF=1 at the 9th tap, DOUT stable at the first word; release ready -> exactly 8 pops.
- Full + simultaneous push/pop: FIFO full, DOUT_READY=1 while the tap is high each cycle -> no drop, OVF=0, occupancy stays 8.
- Drain: last D_READY at edge 50 with END_SIM=1 at the same edge -> the final word is delivered, then DONE=1 no earlier than edge 56.
- Async reset: assert RST_n=0 mid-burst between edges -> outputs immediately DOUT_VALID=0, RESULT_CNT=0, DONE=0, OVF=0; normal behaviour after release.
